// File: rtl/lut_sched_pkg.sv
// Shared types and constants for the time-multiplexed LED truth-table evaluator.
package lut_sched_pkg;

  localparam int TBL_W     = 16;
  localparam int SW_W      = 4;
  localparam int MAX_OUT   = 8;
  localparam int CFG_IDX_W = 4;  // wide enough to hold any idx up to MAX_OUT and compare against it

  typedef enum logic [1:0] {SAMPLE, EVAL, COMMIT} state_t;

  // T0 = S1&S2, T1 = S1|S3|S4, T2 = S3&~(S2&S4), T3 = S1&S2&S3&S4
  localparam logic [TBL_W-1:0] DEFAULT_TABLES [4] = '{16'h8888, 16'hFFFA, 16'h30F0, 16'h8000};

  typedef struct packed {
    logic [CFG_IDX_W-1:0] idx;
    logic [TBL_W-1:0]     tbl;
  } lut_cfg_t;

  function automatic logic [TBL_W-1:0] default_table(input int k);
    if (k < 4) return DEFAULT_TABLES[k];
    else       return '0;
  endfunction

endpackage

// File: rtl/lut_eval_scheduler_if.sv
// Truth-table config port: valid/ready write of one 16-bit table to a selected output.
interface lut_eval_scheduler_if
  import lut_sched_pkg::*;
#(
  parameter int NUM_OUT = 4
);
  logic                       i_Cfg_Valid;
  logic                       o_Cfg_Ready;
  logic [$clog2(NUM_OUT)-1:0] i_Cfg_Idx;
  logic [TBL_W-1:0]           i_Cfg_Table;

  modport master (output i_Cfg_Valid, i_Cfg_Idx, i_Cfg_Table, input o_Cfg_Ready);
  modport slave  (input i_Cfg_Valid, i_Cfg_Idx, i_Cfg_Table, output o_Cfg_Ready);
endinterface

// File: rtl/lut_eval_scheduler_debounce.sv
// Single-bit switch debounce: output follows input after DEBOUNCE_CYCLES stable cycles.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Any return to the current output level restarts the stability count.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lut_eval_scheduler.sv
// Sequenced 4-input truth-table evaluator driving NUM_OUT LEDs from the board switches.
// Optional build macro SWITCH_DEBOUNCE_EN inserts a debounce filter per switch bit.
module lut_eval_scheduler
  import lut_sched_pkg::*;
#(
  parameter int NUM_OUT         = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [SW_W-1:0]      i_Switch,
  lut_eval_scheduler_if.slave  cfg,
  output logic [NUM_OUT-1:0]   o_LED,
  output logic                 o_Update
);
  localparam int IDX_W = $clog2(NUM_OUT);

  if (NUM_OUT < 2 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("NUM_OUT out of range");
  end

  // Async assert, clock-aligned release for all internal state.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [SW_W-1:0] sw_meta, sw_sync, sw_cond;

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_Switch;
      sw_sync <= sw_meta;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  for (genvar b = 0; b < SW_W; b++) begin : g_db
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .gclk   (i_Clk),
      .grst_n (rst_n),
      .d      (sw_sync[b]),
      .q      (sw_cond[b])
    );
  end
`else
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be positive");
  end
  assign sw_cond = sw_sync;
`endif

  state_t           state, state_nx;
  logic [IDX_W-1:0] eval_idx;
  logic [SW_W-1:0]  sw_snap;
  logic [NUM_OUT-1:0] r_next;
  logic [TBL_W-1:0] tables [NUM_OUT];
  logic [TBL_W-1:0] cur_tbl;
  lut_cfg_t         cfg_buf;
  logic             buf_full;
  logic             apply_buf;
  logic             cfg_fire;

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) state <= SAMPLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_Update  = 1'b0;
    apply_buf = 1'b0;
    case (state)
      SAMPLE: state_nx = EVAL;
      EVAL:   if (eval_idx == IDX_W'(NUM_OUT - 1)) state_nx = COMMIT;
      COMMIT: begin
        state_nx  = SAMPLE;
        o_Update  = 1'b1;
        apply_buf = buf_full;
      end
      default: state_nx = SAMPLE;
    endcase
  end

  // Single shared evaluator: one table row is looked up per EVAL cycle.
  assign cur_tbl = tables[eval_idx];

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_snap  <= '0;
      eval_idx <= '0;
      r_next   <= '0;
      o_LED    <= '0;
    end else begin
      case (state)
        SAMPLE: begin
          sw_snap  <= sw_cond;
          eval_idx <= '0;
        end
        EVAL: begin
          r_next[eval_idx] <= cur_tbl[sw_snap];
          eval_idx         <= eval_idx + 1'b1;
        end
        COMMIT:  o_LED <= r_next;
        default: ;
      endcase
    end
  end

  assign cfg.o_Cfg_Ready = ~buf_full;
  assign cfg_fire        = cfg.i_Cfg_Valid & ~buf_full;

  // Draining in COMMIT wins; ready only reappears the following cycle.
  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      cfg_buf  <= '0;
    end else if (apply_buf) begin
      buf_full <= 1'b0;
    end else if (cfg_fire) begin
      buf_full    <= 1'b1;
      cfg_buf.idx <= CFG_IDX_W'(cfg.i_Cfg_Idx);
      cfg_buf.tbl <= cfg.i_Cfg_Table;
    end
  end

  // Out-of-range indices match no table, so those writes are simply dropped.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_tbl
    logic [TBL_W-1:0] tbl_q;

    always_ff @(posedge i_Clk or negedge rst_n) begin
      if (!rst_n)
        tbl_q <= default_table(k);
      else if (apply_buf && cfg_buf.idx == CFG_IDX_W'(k))
        tbl_q <= cfg_buf.tbl;
    end

    assign tables[k] = tbl_q;
  end

endmodule

// File: tb/tb_lut_eval_scheduler.sv
// Directed bench for lut_eval_scheduler: default tables, config handshake, reset, NUM_OUT=3 range.
module tb_lut_eval_scheduler;
  import lut_sched_pkg::*;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int SETTLE = 5;
`else
  localparam int SETTLE = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw, sw3;
  logic [3:0] led;
  logic [2:0] led3;
  logic       upd, upd3;

  lut_eval_scheduler_if #(.NUM_OUT(4)) cfg ();
  lut_eval_scheduler_if #(.NUM_OUT(3)) cfg3 ();

  always #5 clk = ~clk;

  lut_eval_scheduler #(.NUM_OUT(4), .DEBOUNCE_CYCLES(8)) u_dut (
    .i_Clk (clk), .i_Rst_L (rst_n), .i_Switch (sw), .cfg (cfg.slave),
    .o_LED (led), .o_Update (upd)
  );

  lut_eval_scheduler #(.NUM_OUT(3), .DEBOUNCE_CYCLES(8)) u_dut3 (
    .i_Clk (clk), .i_Rst_L (rst_n), .i_Switch (sw3), .cfg (cfg3.slave),
    .o_LED (led3), .o_Update (upd3)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] led;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out waiting, expected an event", name);
  endtask

  // Steps past n commit pulses and returns on the negedge after the last one.
  task automatic wait_commit(input int n, input bit d3);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      while (!(d3 ? upd3 : upd) && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) timeout("commit_wait");
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input bit d3, input logic [1:0] idx, input logic [15:0] tbl,
                           output int waited);
    waited = 0;
    if (d3) begin
      cfg3.i_Cfg_Valid = 1'b1; cfg3.i_Cfg_Idx = idx; cfg3.i_Cfg_Table = tbl;
    end else begin
      cfg.i_Cfg_Valid = 1'b1; cfg.i_Cfg_Idx = idx; cfg.i_Cfg_Table = tbl;
    end
    while (!(d3 ? cfg3.o_Cfg_Ready : cfg.o_Cfg_Ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) timeout("cfg_ready_wait");
    @(negedge clk);
    if (d3) cfg3.i_Cfg_Valid = 1'b0;
    else    cfg.i_Cfg_Valid  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w2, t, p;
    bit glitch;

    vecs[0] = '{4'b0000, 4'b0000};
    vecs[1] = '{4'b0011, 4'b0011};
    vecs[2] = '{4'b1111, 4'b1011};
    vecs[3] = '{4'b0100, 4'b0110};
    vecs[4] = '{4'b0001, 4'b0010};
    vecs[5] = '{4'b1100, 4'b0110};
    vecs[6] = '{4'b1110, 4'b0010};
    vecs[7] = '{4'b0010, 4'b0000};
    vecs[8] = '{4'b1011, 4'b0011};

    rst_n = 1'b0; sw = 4'b0011; sw3 = 4'b0000;
    cfg.i_Cfg_Valid  = 1'b0; cfg.i_Cfg_Idx  = '0; cfg.i_Cfg_Table  = '0;
    cfg3.i_Cfg_Valid = 1'b0; cfg3.i_Cfg_Idx = '0; cfg3.i_Cfg_Table = '0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 4'b0000);
    check("rst_update", upd, 1'b0);
    check("rst_ready", cfg.o_Cfg_Ready, 1'b1);
    check("rst_led3", led3, 3'b000);

    // Release reset with S1,S2 on: LED1/LED2 light within the latency bound.
    rst_n = 1'b1;
    t = 0;
    while (led !== 4'b0011 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("rst_release_led", led, 4'b0011);
`ifndef SWITCH_DEBOUNCE_EN
    check("rst_release_latency_ok", (t <= 16), 1'b1);
`endif

    t = 0;
    while (!upd && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) timeout("update_first");
    @(negedge clk);
    check("update_width", upd, 1'b0);
    p = 1;
    while (!upd && p < 20) begin @(negedge clk); p++; end
    check("update_period", p, 6);

    for (int i = 0; i < 9; i++) begin
      sw = vecs[i].sw;
      wait_commit(SETTLE, 1'b0);
      check($sformatf("vec%0d_sw%b", i, vecs[i].sw), led, vecs[i].led);
    end

    // Config write: T2 <- FFFF with all switches off.
    sw = 4'b0000;
    wait_commit(SETTLE, 1'b0);
    check("cfg_pre_led", led, 4'b0000);
    cfg_write(1'b0, 2'd2, 16'hFFFF, w);
    check("cfg_ready_drop", cfg.o_Cfg_Ready, 1'b0);
    t = 0;
    while (!upd && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) timeout("cfg_commit");
    check("cfg_ready_in_commit", cfg.o_Cfg_Ready, 1'b0);
    @(negedge clk);
    check("cfg_ready_rise", cfg.o_Cfg_Ready, 1'b1);
    wait_commit(1, 1'b0);
    check("cfg_led3_on", led, 4'b0100);

    // Back-to-back writes: second must stall until the first drains.
    sw = 4'b1111;
    wait_commit(SETTLE, 1'b0);
    check("bp_pre_led", led, 4'b1111);
    cfg_write(1'b0, 2'd0, 16'h0000, w);
    cfg_write(1'b0, 2'd1, 16'h0000, w2);
    check("bp_first_no_wait", w, 0);
    check("bp_second_held", (w2 > 0), 1'b1);
    wait_commit(2, 1'b0);
    check("bp_led_1111", led, 4'b1100);
    check("bp_drained", cfg.o_Cfg_Ready, 1'b1);
    sw = 4'b0011;
    wait_commit(SETTLE, 1'b0);
    check("bp_led_0011", led, 4'b0100);

    // Reset with a write still buffered: defaults come back, write is lost.
    cfg_write(1'b0, 2'd3, 16'h0000, w);
    check("rstbuf_full", cfg.o_Cfg_Ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstbuf_led_zero", led, 4'b0000);
    check("rstbuf_ready", cfg.o_Cfg_Ready, 1'b1);
    repeat (2) @(negedge clk);
    check("rstbuf_led_held", led, 4'b0000);
    sw = 4'b1111;
    rst_n = 1'b1;
    wait_commit(SETTLE, 1'b0);
    check("rstbuf_defaults", led, 4'b1011);

    // NUM_OUT=3: idx 3 is accepted but changes nothing.
    check("n3_idle", led3, 3'b000);
    cfg_write(1'b1, 2'd3, 16'hFFFF, w);
    check("n3_oor_accepted", cfg3.o_Cfg_Ready, 1'b0);
    wait_commit(SETTLE, 1'b1);
    check("n3_oor_led", led3, 3'b000);
    check("n3_oor_ready", cfg3.o_Cfg_Ready, 1'b1);
    cfg_write(1'b1, 2'd1, 16'hFFFF, w);
    wait_commit(SETTLE, 1'b1);
    check("n3_idx1_led", led3, 3'b010);

`ifdef SWITCH_DEBOUNCE_EN
    sw = 4'b0000;
    wait_commit(SETTLE, 1'b0);
    glitch = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) sw[0] = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (led !== 4'b0000) glitch = 1'b1;
    end
    check("db_no_glitch", glitch, 1'b0);
    sw[0] = 1'b1;
    t = 0;
    while (led !== 4'b0010 && t < 60) begin @(negedge clk); t++; end
    check("db_settled_led", led, 4'b0010);
    check("db_latency_min", (t >= 10), 1'b1);
`else
    glitch = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lut_eval_scheduler.md
Name: lut_eval_scheduler

Overview:
- Time-multiplexes one shared 4-input truth-table evaluator across NUM_OUT LED outputs on the Go Board switch/LED datapath.
- Holds one 16-bit truth table per output in registers, with fixed power-on defaults.
- Each table is reprogrammable at run time through a valid/ready config port with a one-entry holding buffer.
- Sits between the switch input pads and the LED output pads, replacing the four fixed LUTs with a sequenced, configurable evaluator.

Parameters:
- NUM_OUT, 4, number of LED outputs / truth tables (2..8).
- DEBOUNCE_CYCLES, 250000, stable-cycle count required by the debounce filter; used only with SWITCH_DEBOUNCE_EN.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Switch  in  4  raw switches; bit0 = Switch_1 … bit3 = Switch_4.
- i_Cfg_Valid  in  1  config write request.
- o_Cfg_Ready  out  1  holding buffer empty, write accepted this cycle if valid.
- i_Cfg_Idx  in  $clog2(NUM_OUT)  table to overwrite.
- i_Cfg_Table  in  16  new truth table.
- o_LED  out  NUM_OUT  registered LED outputs.
- o_Update  out  1  one-cycle pulse when o_LED is refreshed.

Behaviour:
- Input conditioning:
  - i_Switch always passes through a 2-flop synchronizer, giving sw_sync.
  - Table lookup index = {S4,S3,S2,S1} = sw_snap[3:0].
  - Output k = table[k][index].
- Reset (async assert, sync-safe deassert):
  - State = SAMPLE; o_LED = 0; o_Update = 0; o_Cfg_Ready = 1; holding buffer empty.
  - Tables load defaults: T0=16'h8888 (S1&S2), T1=16'hFFFA (S1|S3|S4), T2=16'h30F0 (S3&~(S2&S4)), T3=16'h8000 (all four).
  - Tables above 3 default to 0.
- FSM states: SAMPLE -> EVAL -> COMMIT -> SAMPLE; one sweep takes NUM_OUT+2 cycles.
  - SAMPLE: sw_snap <= conditioned switches; eval_idx <= 0.
  - EVAL: r_next[eval_idx] <= table[eval_idx][sw_snap]. eval_idx increments each cycle; leave EVAL after eval_idx == NUM_OUT-1.
  - COMMIT: o_LED <= r_next; o_Update = 1 for exactly this cycle. If the buffer is full, table[buf_idx] <= buf_table and the buffer clears.
- Latency: a switch change reaches o_LED within 2 (sync) + 2*(NUM_OUT+2) cycles, worst case 14 cycles for NUM_OUT=4.
- Config handshake:
  - o_Cfg_Ready = buffer empty.
  - Transfer occurs when i_Cfg_Valid && o_Cfg_Ready; idx and table are captured into the buffer.
  - The buffer is applied only in COMMIT, so tables never change mid-sweep. A new table affects the sweep that starts after that COMMIT.
  - Full buffer: o_Cfg_Ready = 0; the requester holds valid and data stable until ready.
  - Buffer applied in COMMIT: ready rises the next cycle. No same-cycle drain and refill.
  - i_Cfg_Idx >= NUM_OUT: the write is accepted and discarded at COMMIT, and no table changes.
- Reset mid-sweep or with buffer full: everything returns to reset values. The buffered write is lost and defaults are restored.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EN.
- Defined: each synchronized switch bit feeds a switch_debounce instance. Its output updates only after the input has held a new level for DEBOUNCE_CYCLES consecutive cycles; the counter resets on any bounce. Reset output = 0.
- Undefined: sw_sync feeds SAMPLE directly, with no counters and DEBOUNCE_CYCLES unused. Latency is as stated above.

Decomposition:
- Package lut_sched_pkg holds:
  - state enum {SAMPLE, EVAL, COMMIT};
  - TBL_W = 16 and SW_W = 4;
  - DEFAULT_TABLES constant array (T0..T3);
  - lut_cfg_t struct {idx, table}, used for the holding buffer.
- One sub-module: switch_debounce (1-bit, DEBOUNCE_CYCLES counter), instantiated only under SWITCH_DEBOUNCE_EN.

Test Plan:
- Reset defaults: hold i_Rst_L=0, then release with i_Switch=4'b0011 -> within 14 cycles o_LED=4'b0011 (LED1=1, LED2=1, LED3=0, LED4=0), one o_Update pulse every 6 cycles.
- All switches on: i_Switch=4'b1111 -> o_LED=4'b1011 (T2 bit15=0).
- Config write: write idx=2, table=16'hFFFF with S=4'b0000 -> o_Cfg_Ready drops, LED3 goes 1 at the second COMMIT at the latest, ready rises the cycle after the apply.
- Backpressure: issue two back-to-back writes (idx0=16'h0000, idx1=16'h0000) -> the second is held with ready=0 until the first applies; both tables end at 0, no write lost or duplicated.
- Out-of-range and reset: write idx=3 then assert reset before COMMIT -> T3 stays 16'h8000, o_LED=0 during reset. Separately, with NUM_OUT=4, a 2-bit idx cannot exceed 3, so the out-of-range check uses NUM_OUT=3 with idx=3 -> no table change.
- Debounce (SWITCH_DEBOUNCE_EN, DEBOUNCE_CYCLES=8): toggle S1 every 3 cycles for 30 cycles, then hold at 1 -> LED inputs see S1=1 only after 8 stable cycles; no o_LED glitch during bouncing.
